// File: rtl/multistep_pkg.sv
// ----------------------------------------------------------------------------
// multistep_pkg
// Shared definitions for the multi-channel stepper/encoder move controller:
//   - chan_state_e      : per-channel FSM state encoding
//   - SYNC_DEPTH        : number of flops in the encoder synchroniser
//   - DEFAULT_CNT_W     : default width of target/remaining counters
//   - DEFAULT_STALL_CYC : default stall timeout (100 ms at 16 MHz)
// ----------------------------------------------------------------------------
package multistep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_STALL = 2'd3
    } chan_state_e;

    localparam int unsigned SYNC_DEPTH        = 2;
    localparam int unsigned DEFAULT_CNT_W     = 16;
    localparam logic [31:0] DEFAULT_STALL_CYC = 32'd1_600_000;

endpackage

// File: rtl/multistep_chan.sv
// ----------------------------------------------------------------------------
// multistep_chan
// One motor channel: encoder synchroniser + edge detector, move FSM
// (IDLE/RUN/DONE/STALL) and the remaining-distance counter.
//
// Optional feature macro: STALL_DETECT_EN
//   defined   -> a RUN timer moves the channel to STALL after STALL_CYC clocks
//                without an encoder pulse
//   undefined -> no timer exists, STALL is unreachable, stall is tied 0
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   start     in   move request (level, sampled every clock)
//   abort     in   abort request, wins over start and over the final pulse
//   target    in   distance to travel, sampled only on the accepting edge
//   encoder   in   raw asynchronous encoder signal
//   motor_en  out  registered motor enable (high only in RUN)
//   busy      out  channel is not IDLE
//   done      out  one-cycle completion pulse
//   stall     out  stall flag, held until abort or a new start
//   remaining out  distance still to travel
// ----------------------------------------------------------------------------
module multistep_chan
    import multistep_pkg::*;
#(
    parameter int unsigned CNT_W = DEFAULT_CNT_W
`ifdef STALL_DETECT_EN
    ,
    parameter logic [31:0] STALL_CYC = DEFAULT_STALL_CYC
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] target,
    input  logic             encoder,
    output logic             motor_en,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [CNT_W-1:0] remaining
);

    chan_state_e            state_q, state_d;
    logic [CNT_W-1:0]       remaining_q, remaining_d;
    logic                   motor_en_q, motor_en_d;
    logic [SYNC_DEPTH-1:0]  sync_q, sync_d;
    logic                   enc_prev_q, enc_prev_d;
    logic                   pulse;
    logic                   timeout;

    // The synchroniser shifts the raw encoder in; the edge register holds the
    // previous synchronised value so a rising edge yields a single-cycle pulse
    // that the FSM consumes on the third clock after the raw edge.
    always_comb begin
        sync_d     = {sync_q[SYNC_DEPTH-2:0], encoder};
        enc_prev_d = sync_q[SYNC_DEPTH-1];
        pulse      = sync_q[SYNC_DEPTH-1] & ~enc_prev_q;
    end

`ifdef STALL_DETECT_EN
    logic [31:0] timer_q, timer_d;

    // Timer counts RUN cycles since entry or since the last pulse; it fires on
    // the edge where the count would reach STALL_CYC.
    always_comb begin
        timeout = (state_q == ST_RUN) && (timer_q == STALL_CYC - 32'd1);
        timer_d = '0;
        if ((state_q == ST_RUN) && (state_d == ST_RUN) && !pulse) begin
            timer_d = timer_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state logic. Abort is checked first everywhere so it wins over a
    // simultaneous start or final pulse; a start in STALL behaves as in IDLE.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        unique case (state_q)
            ST_IDLE, ST_STALL: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d     = (target == '0) ? ST_DONE : ST_RUN;
                    remaining_d = target;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (pulse) begin
                    // <= 1 also covers a zero count so the counter cannot wrap
                    if (remaining_q <= CNT_W'(1)) begin
                        state_d     = ST_DONE;
                        remaining_d = '0;
                    end else begin
                        remaining_d = remaining_q - CNT_W'(1);
                    end
                end else if (timeout) begin
                    state_d = ST_STALL;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        motor_en_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            motor_en_q  <= 1'b0;
            sync_q      <= '0;
            enc_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            motor_en_q  <= motor_en_d;
            sync_q      <= sync_d;
            enc_prev_q  <= enc_prev_d;
        end
    end

    assign motor_en  = motor_en_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign remaining = remaining_q;
`ifdef STALL_DETECT_EN
    assign stall     = (state_q == ST_STALL);
`else
    assign stall     = 1'b0;
`endif

endmodule

// File: rtl/multistep_ctl.sv
// ----------------------------------------------------------------------------
// multistep_ctl
// Top level: NCH independent multistep_chan instances; this level only slices
// the flattened per-channel buses.
//
// Optional feature macro: STALL_DETECT_EN (stall timeout, see multistep_chan)
//
// Ports:
//   clk       in   16 MHz system clock
//   rst_n     in   asynchronous active-low reset
//   start     in   [NCH]        per-channel start request
//   abort     in   [NCH]        per-channel abort request
//   target    in   [NCH*CNT_W]  channel i at [i*CNT_W +: CNT_W]
//   encoder   in   [NCH]        raw asynchronous encoder inputs
//   motor_en  out  [NCH]        registered motor enables
//   busy      out  [NCH]        channel not IDLE
//   done      out  [NCH]        one-cycle completion pulses
//   stall     out  [NCH]        stall flags
//   remaining out  [NCH*CNT_W]  per-channel remaining distance
// ----------------------------------------------------------------------------
module multistep_ctl
    import multistep_pkg::*;
#(
    parameter int unsigned NCH       = 2,
    parameter int unsigned CNT_W     = DEFAULT_CNT_W,
    parameter logic [31:0] STALL_CYC = DEFAULT_STALL_CYC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       start,
    input  logic [NCH-1:0]       abort,
    input  logic [NCH*CNT_W-1:0] target,
    input  logic [NCH-1:0]       encoder,
    output logic [NCH-1:0]       motor_en,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       done,
    output logic [NCH-1:0]       stall,
    output logic [NCH*CNT_W-1:0] remaining
);

    // Reject unsupported configurations at elaboration time.
    if ((NCH < 1) || (NCH > 8) || (CNT_W < 1) || (STALL_CYC == 32'd0)) begin : g_bad_cfg
        $error("multistep_ctl: unsupported parameter set");
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        multistep_chan #(
            .CNT_W     (CNT_W)
`ifdef STALL_DETECT_EN
            ,
            .STALL_CYC (STALL_CYC)
`endif
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start[i]),
            .abort     (abort[i]),
            .target    (target[i*CNT_W +: CNT_W]),
            .encoder   (encoder[i]),
            .motor_en  (motor_en[i]),
            .busy      (busy[i]),
            .done      (done[i]),
            .stall     (stall[i]),
            .remaining (remaining[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_multistep_ctl.sv
// ----------------------------------------------------------------------------
// tb_multistep_ctl
// Self-checking bench for multistep_ctl (NCH=2, CNT_W=16, STALL_CYC=100).
// Directed table of move operations, cycle-exact hand sequences for the
// timing corners, and random operations against a move-level model.
// The stall sequence is compiled only when STALL_DETECT_EN is defined.
// ----------------------------------------------------------------------------
module tb_multistep_ctl;

    localparam int NCH   = 2;
    localparam int CNT_W = 16;

    typedef enum int {OP_NOP, OP_START, OP_PULSE, OP_PULSE_BOTH, OP_ABORT, OP_START_ABORT} op_e;

    typedef struct {
        op_e op;
        int  ch;
        int  tgt;
        int  exp_rem;
        bit  exp_busy;
        int  exp_done;
    } vec_t;

    logic                 clk;
    logic                 rst_n;
    logic [NCH-1:0]       start;
    logic [NCH-1:0]       abort;
    logic [NCH*CNT_W-1:0] target;
    logic [NCH-1:0]       encoder;
    logic [NCH-1:0]       motor_en;
    logic [NCH-1:0]       busy;
    logic [NCH-1:0]       done;
    logic [NCH-1:0]       stall;
    logic [NCH*CNT_W-1:0] remaining;

    int checks = 0;
    int errors = 0;
    int done_cnt [NCH];
    int done_base [NCH];

    // Move-level reference model: is the channel moving, how far is left,
    // how many completions have been signalled.
    bit m_run  [NCH];
    int m_rem  [NCH];
    int m_done [NCH];

    multistep_ctl #(
        .NCH       (NCH),
        .CNT_W     (CNT_W),
        .STALL_CYC (32'd100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .target    (target),
        .encoder   (encoder),
        .motor_en  (motor_en),
        .busy      (busy),
        .done      (done),
        .stall     (stall),
        .remaining (remaining)
    );

    // Free-running 100 MHz bench clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count completion pulses using the value held just before each edge.
    initial begin
        for (int i = 0; i < NCH; i++) done_cnt[i] = 0;
    end
    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (done[i] === 1'b1) done_cnt[i]++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] remOf(input int ch);
        return remaining[ch*CNT_W +: CNT_W];
    endfunction

    task automatic checkOutput(input string tag, input int ch, input int exp_rem,
                               input bit exp_busy, input int exp_done);
        checkVal($sformatf("%s ch%0d motor_en", tag, ch), 32'(motor_en[ch]), 32'(exp_busy));
        checkVal($sformatf("%s ch%0d busy", tag, ch), 32'(busy[ch]), 32'(exp_busy));
        checkVal($sformatf("%s ch%0d remaining", tag, ch), 32'(remOf(ch)), 32'(exp_rem));
        checkVal($sformatf("%s ch%0d stall", tag, ch), 32'(stall[ch]), 32'd0);
        checkVal($sformatf("%s ch%0d done count", tag, ch), 32'(done_cnt[ch] - done_base[ch]),
                 32'(exp_done));
    endtask

    task automatic applyStimulus(input op_e op, input int ch, input int tgt);
        case (op)
            OP_START, OP_START_ABORT: begin
                target[ch*CNT_W +: CNT_W] = CNT_W'(tgt);
                start[ch] = 1'b1;
                if (op == OP_START_ABORT) abort[ch] = 1'b1;
                tick(1);
                start[ch] = 1'b0;
                abort[ch] = 1'b0;
                tick(2);
            end
            OP_PULSE: begin
                encoder[ch] = 1'b1;
                tick(4);
                encoder[ch] = 1'b0;
                tick(4);
            end
            OP_PULSE_BOTH: begin
                encoder = '1;
                tick(4);
                encoder = '0;
                tick(4);
            end
            OP_ABORT: begin
                abort[ch] = 1'b1;
                tick(1);
                abort[ch] = 1'b0;
                tick(2);
            end
            default: tick(1);
        endcase
    endtask

    function automatic void modelPulse(input int ch);
        if (m_run[ch]) begin
            m_rem[ch]--;
            if (m_rem[ch] == 0) begin
                m_run[ch] = 0;
                m_done[ch]++;
            end
        end
    endfunction

    function automatic void modelApply(input op_e op, input int ch, input int tgt);
        case (op)
            OP_START: begin
                if (!m_run[ch]) begin
                    m_rem[ch] = tgt;
                    if (tgt == 0) m_done[ch]++;
                    else m_run[ch] = 1;
                end
            end
            OP_PULSE:       modelPulse(ch);
            OP_PULSE_BOTH:  begin modelPulse(0); modelPulse(1); end
            OP_ABORT, OP_START_ABORT: m_run[ch] = 0;
            default: ;
        endcase
    endfunction

    task automatic doReset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        for (int i = 0; i < NCH; i++) done_base[i] = done_cnt[i];
    endtask

    vec_t vecs [0:20];

    // Main test sequence.
    initial begin
        int base0;
        int base1;
        start   = '0;
        abort   = '0;
        target  = '0;
        encoder = '0;
        rst_n   = 1'b0;
        for (int i = 0; i < NCH; i++) done_base[i] = 0;

        vecs[0]  = '{OP_START,       0, 3, 3, 1'b1, 0};
        vecs[1]  = '{OP_PULSE,       0, 0, 2, 1'b1, 0};
        vecs[2]  = '{OP_PULSE,       0, 0, 1, 1'b1, 0};
        vecs[3]  = '{OP_PULSE,       0, 0, 0, 1'b0, 1};
        vecs[4]  = '{OP_NOP,         1, 0, 0, 1'b0, 0};
        vecs[5]  = '{OP_START,       0, 0, 0, 1'b0, 2};
        vecs[6]  = '{OP_START,       0, 5, 5, 1'b1, 2};
        vecs[7]  = '{OP_PULSE,       0, 0, 4, 1'b1, 2};
        vecs[8]  = '{OP_START,       0, 9, 4, 1'b1, 2};
        vecs[9]  = '{OP_PULSE,       0, 0, 3, 1'b1, 2};
        vecs[10] = '{OP_ABORT,       0, 0, 3, 1'b0, 2};
        vecs[11] = '{OP_PULSE,       0, 0, 3, 1'b0, 2};
        vecs[12] = '{OP_START_ABORT, 0, 6, 3, 1'b0, 2};
        vecs[13] = '{OP_START,       1, 2, 2, 1'b1, 0};
        vecs[14] = '{OP_NOP,         0, 0, 3, 1'b0, 2};
        vecs[15] = '{OP_PULSE,       1, 0, 1, 1'b1, 0};
        vecs[16] = '{OP_ABORT,       1, 0, 1, 1'b0, 0};
        vecs[17] = '{OP_START,       1, 1, 1, 1'b1, 0};
        vecs[18] = '{OP_PULSE,       1, 0, 0, 1'b0, 1};
        vecs[19] = '{OP_PULSE,       1, 0, 0, 1'b0, 1};
        vecs[20] = '{OP_ABORT,       1, 0, 0, 1'b0, 1};

        // Reset state
        tick(3);
        for (int i = 0; i < NCH; i++) checkOutput("reset", i, 0, 1'b0, 0);
        checkVal("reset done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Directed table
        for (int v = 0; v < 21; v++) begin
            applyStimulus(vecs[v].op, vecs[v].ch, vecs[v].tgt);
            checkOutput($sformatf("vec%0d", v), vecs[v].ch, vecs[v].exp_rem,
                        vecs[v].exp_busy, vecs[v].exp_done);
        end

        // Zero target: done one cycle after start, motor never enabled
        target[CNT_W-1:0] = '0;
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        checkVal("zero done", 32'(done[0]), 32'd1);
        checkVal("zero motor_en", 32'(motor_en[0]), 32'd0);
        tick(1);
        checkVal("zero done drop", 32'(done[0]), 32'd0);
        checkVal("zero busy drop", 32'(busy[0]), 32'd0);

        // Cycle-exact move of 2: enable one clock after start, pulse lands
        // three clocks after the raw edge, done lasts exactly one clock
        target[CNT_W-1:0] = 16'd2;
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        checkVal("exact motor_en", 32'(motor_en[0]), 32'd1);
        checkVal("exact rem start", 32'(remOf(0)), 32'd2);
        encoder[0] = 1'b1;
        tick(2);
        checkVal("exact rem before 3rd clk", 32'(remOf(0)), 32'd2);
        tick(1);
        checkVal("exact rem after 3rd clk", 32'(remOf(0)), 32'd1);
        encoder[0] = 1'b0;
        tick(3);
        encoder[0] = 1'b1;
        tick(3);
        checkVal("exact done", 32'(done[0]), 32'd1);
        checkVal("exact done motor_en", 32'(motor_en[0]), 32'd0);
        checkVal("exact done rem", 32'(remOf(0)), 32'd0);
        tick(1);
        checkVal("exact done width", 32'(done[0]), 32'd0);
        checkVal("exact idle", 32'(busy[0]), 32'd0);
        encoder[0] = 1'b0;
        tick(3);

        // Abort on the same clock as the 2nd pulse: no done, remaining held
        base0 = done_cnt[0];
        applyStimulus(OP_START, 0, 5);
        applyStimulus(OP_PULSE, 0, 0);
        encoder[0] = 1'b1;
        tick(2);
        abort[0] = 1'b1;
        tick(1);
        abort[0] = 1'b0;
        checkVal("abort+pulse busy", 32'(busy[0]), 32'd0);
        checkVal("abort+pulse rem", 32'(remOf(0)), 32'd4);
        checkVal("abort+pulse done", 32'(done[0]), 32'd0);
        encoder[0] = 1'b0;
        tick(4);
        checkVal("abort+pulse done count", 32'(done_cnt[0] - base0), 32'd0);

        // Asynchronous reset mid-move
        applyStimulus(OP_START, 0, 7);
        applyStimulus(OP_START, 1, 3);
        checkVal("pre-reset rem", 32'(remOf(0)), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        checkVal("async motor_en", 32'(motor_en), 32'd0);
        checkVal("async busy", 32'(busy), 32'd0);
        checkVal("async remaining", 32'(remaining), 32'd0);
        checkVal("async done", 32'(done), 32'd0);
        checkVal("async stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        for (int i = 0; i < NCH; i++) done_base[i] = done_cnt[i];
        applyStimulus(OP_START, 0, 2);
        applyStimulus(OP_PULSE, 0, 0);
        applyStimulus(OP_PULSE, 0, 0);
        checkOutput("post-reset", 0, 0, 1'b0, 1);

        // Both channels started on the same clock, interleaved pulses
        base0 = done_cnt[0];
        base1 = done_cnt[1];
        target = {16'd4, 16'd2};
        start = 2'b11;
        tick(1);
        start = 2'b00;
        checkVal("dual motor_en", 32'(motor_en), 32'd3);
        tick(2);
        applyStimulus(OP_PULSE_BOTH, 0, 0);
        applyStimulus(OP_PULSE, 0, 0);
        checkVal("dual ch0 done", 32'(done_cnt[0] - base0), 32'd1);
        checkVal("dual ch1 no done", 32'(done_cnt[1] - base1), 32'd0);
        checkVal("dual busy", 32'(busy), 32'd2);
        checkVal("dual ch1 rem", 32'(remOf(1)), 32'd3);
        applyStimulus(OP_PULSE_BOTH, 0, 0);
        applyStimulus(OP_PULSE, 1, 0);
        applyStimulus(OP_PULSE, 1, 0);
        checkVal("dual ch1 done", 32'(done_cnt[1] - base1), 32'd1);
        checkVal("dual ch0 single done", 32'(done_cnt[0] - base0), 32'd1);
        checkVal("dual idle", 32'(busy), 32'd0);

`ifdef STALL_DETECT_EN
        // Stall exactly 100 clocks after the last pulse; new start clears it
        applyStimulus(OP_START, 1, 4);
        encoder[1] = 1'b1;
        tick(3);
        encoder[1] = 1'b0;
        checkVal("stall rem", 32'(remOf(1)), 32'd3);
        tick(99);
        checkVal("stall not yet", 32'(stall[1]), 32'd0);
        tick(1);
        checkVal("stall set", 32'(stall[1]), 32'd1);
        checkVal("stall motor_en", 32'(motor_en[1]), 32'd0);
        checkVal("stall busy", 32'(busy[1]), 32'd1);
        applyStimulus(OP_START, 1, 2);
        checkVal("stall cleared", 32'(stall[1]), 32'd0);
        checkVal("stall restart motor_en", 32'(motor_en[1]), 32'd1);
        checkVal("stall restart rem", 32'(remOf(1)), 32'd2);
`endif

        // Random operations against the move-level model, in bursts short
        // enough that no running channel can time out
        doReset();
        for (int i = 0; i < NCH; i++) begin
            m_run[i] = 0;
            m_rem[i] = 0;
            m_done[i] = 0;
        end
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < 8; k++) begin
                int  r;
                int  ch;
                int  tgt;
                op_e op;
                r   = int'($urandom_range(0, 9));
                ch  = int'($urandom_range(0, 1));
                tgt = int'($urandom_range(0, 5));
                if (r <= 2)      op = OP_START;
                else if (r <= 7) op = OP_PULSE;
                else if (r == 8) op = OP_ABORT;
                else             op = OP_PULSE_BOTH;
                applyStimulus(op, ch, tgt);
                modelApply(op, ch, tgt);
                for (int i = 0; i < NCH; i++)
                    checkOutput($sformatf("rand b%0d k%0d", b, k), i, m_rem[i], m_run[i], m_done[i]);
            end
            for (int i = 0; i < NCH; i++) begin
                applyStimulus(OP_ABORT, i, 0);
                modelApply(OP_ABORT, i, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
